spwm_carrier_pwm: RTL and testbench

- Parametrised triangle-carrier SPWM core with integrated up/down counter, peak/valley dwell, and NCH compare channels.
- Replaces separate incrementer/decrementer plus direction-select logic.
- Sits between the sine-reference LUT/sequencer (supplies modulation words) and the gate-drive output stage.
- Peak, dwell and modulation words are double-buffered and take effect only at the carrier valley.

---
 rtl/spwm_carrier_pwm_pkg.sv | 9 +
 rtl/spwm_carrier_pwm_if.sv | 28 ++
 rtl/spwm_carrier_pwm_deadband.sv | 51 +++++
 rtl/spwm_carrier_pwm.sv | 144 ++++++++++++++
 tb/tb_spwm_carrier_pwm.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/spwm_carrier_pwm_pkg.sv
// Shared types and default constants for the triangle-carrier SPWM core.
package spwm_pkg;

    typedef enum logic [1:0] {BOT, RISE, TOP, FALL} spwm_state_e;

    localparam int CARRIER_W    = 15;
    localparam int PEAK_DEFAULT = 15358;

endpackage

// File: rtl/spwm_carrier_pwm_if.sv
// Control/status bundle between the sine sequencer (master) and the SPWM core (slave).
interface spwm_carrier_pwm_if #(
    parameter int WIDTH   = 15,
    parameter int NCH     = 3,
    parameter int DWELL_W = 4
);
    logic                   en;
    logic [WIDTH-1:0]       peak;
    logic [DWELL_W-1:0]     dwell;
    logic [NCH*WIDTH-1:0]   mod_in;
    logic                   mod_wr;
    logic [WIDTH-1:0]       carrier;
    logic                   dir_up;
    logic                   sync_pulse;
    logic                   top_pulse;
    logic [NCH-1:0]         pwm_out;
    logic [NCH-1:0]         pwm_n;

    modport master (
        output en, peak, dwell, mod_in, mod_wr,
        input  carrier, dir_up, sync_pulse, top_pulse, pwm_out, pwm_n
    );

    modport slave (
        input  en, peak, dwell, mod_in, mod_wr,
        output carrier, dir_up, sync_pulse, top_pulse, pwm_out, pwm_n
    );
endinterface

// File: rtl/spwm_carrier_pwm_deadband.sv
// Single-channel dead-time generator; only present when SPWM_DEADTIME_EN is defined.
`ifdef SPWM_DEADTIME_EN
module spwm_deadband #(
    parameter int DEADTIME = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic pwm_hi,
    output logic pwm_lo
);
    localparam int            CW   = (DEADTIME > 2) ? $clog2(DEADTIME) : 1;
    localparam logic [CW-1:0] LOAD = (DEADTIME > 1) ? CW'(DEADTIME - 1) : CW'(1);

    logic          raw_q, hi_q, lo_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= 1'b0;
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
            cnt   <= LOAD;
        end else if (en) begin
            if (raw != raw_q) begin
                raw_q <= raw;
                if (DEADTIME <= 1) begin
                    hi_q <= raw;
                    lo_q <= ~raw;
                    cnt  <= '0;
                end else begin
                    hi_q <= 1'b0;
                    lo_q <= 1'b0;
                    cnt  <= LOAD;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    hi_q <= raw_q;
                    lo_q <= ~raw_q;
                end
            end
        end
    end

    // Masking with the live raw bit drops the active side in the same cycle raw moves.
    assign pwm_hi = hi_q & (raw == raw_q);
    assign pwm_lo = lo_q & (raw == raw_q);
endmodule
`endif

// File: rtl/spwm_carrier_pwm.sv
// Triangle-carrier SPWM core: up/down carrier with peak/valley dwell and NCH compare channels.
// Build option SPWM_DEADTIME_EN inserts a per-channel dead-band stage on the outputs.
module spwm_carrier_pwm
    import spwm_pkg::*;
#(
    parameter int WIDTH    = CARRIER_W,
    parameter int NCH      = 3,
    parameter int DWELL_W  = 4,
    parameter int PEAK_DEF = PEAK_DEFAULT,
    parameter int DEADTIME = 8
) (
    input  logic              clk,
    input  logic              rst,
    spwm_carrier_pwm_if.slave bus
);
    spwm_state_e                  state, state_nxt;
    logic [WIDTH-1:0]             carrier_q, carrier_nxt, peak_act;
    logic [DWELL_W-1:0]           hold_q, hold_nxt, dwell_act;
    logic [NCH-1:0][WIDTH-1:0]    mod_shadow, mod_act, mod_in_w;
    logic [NCH-1:0]               raw, raw_nxt;
    logic                         valley, top_ent, sync_q, top_q;

    assign mod_in_w = bus.mod_in;

    always_comb begin
        state_nxt   = state;
        carrier_nxt = carrier_q;
        hold_nxt    = hold_q;
        valley      = 1'b0;
        top_ent     = 1'b0;
        unique case (state)
            BOT: begin
                if (hold_q != '0) begin
                    hold_nxt = hold_q - DWELL_W'(1);
                end else begin
                    carrier_nxt = WIDTH'(1);
                    // A peak of 1 has no rising ramp: the first step already lands on the peak.
                    if (peak_act == WIDTH'(1)) begin
                        state_nxt = TOP;
                        hold_nxt  = dwell_act;
                        top_ent   = 1'b1;
                    end else begin
                        state_nxt = RISE;
                    end
                end
            end
            RISE: begin
                carrier_nxt = carrier_q + WIDTH'(1);
                if (carrier_nxt == peak_act) begin
                    state_nxt = TOP;
                    hold_nxt  = dwell_act;
                    top_ent   = 1'b1;
                end
            end
            TOP: begin
                if (hold_q != '0) begin
                    hold_nxt = hold_q - DWELL_W'(1);
                end else begin
                    carrier_nxt = peak_act - WIDTH'(1);
                    if (carrier_nxt == '0) begin
                        state_nxt = BOT;
                        valley    = 1'b1;
                        hold_nxt  = bus.dwell;
                    end else begin
                        state_nxt = FALL;
                    end
                end
            end
            FALL: begin
                carrier_nxt = carrier_q - WIDTH'(1);
                if (carrier_nxt == '0) begin
                    state_nxt = BOT;
                    valley    = 1'b1;
                    hold_nxt  = bus.dwell;
                end
            end
            default: state_nxt = BOT;
        endcase
    end

    always_comb begin
        raw_nxt = '0;
        for (int i = 0; i < NCH; i++) raw_nxt[i] = mod_act[i] > carrier_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOT;
            carrier_q  <= '0;
            hold_q     <= '0;
            peak_act   <= WIDTH'(PEAK_DEF);
            dwell_act  <= '0;
            mod_shadow <= '0;
            mod_act    <= '0;
            raw        <= '0;
            sync_q     <= 1'b0;
            top_q      <= 1'b0;
        end else begin
            if (bus.mod_wr) mod_shadow <= mod_in_w;
            if (bus.en) begin
                state     <= state_nxt;
                carrier_q <= carrier_nxt;
                hold_q    <= hold_nxt;
                raw       <= raw_nxt;
                sync_q    <= valley;
                top_q     <= top_ent;
                // Valley load: mod_act takes the shadow as it was before any same-edge write.
                if (valley) begin
                    peak_act  <= (bus.peak == '0) ? WIDTH'(1) : bus.peak;
                    dwell_act <= bus.dwell;
                    mod_act   <= mod_shadow;
                end
            end
        end
    end

    assign bus.carrier    = carrier_q;
    assign bus.dir_up     = (state == BOT) || (state == RISE);
    assign bus.sync_pulse = sync_q;
    assign bus.top_pulse  = top_q;

`ifdef SPWM_DEADTIME_EN
    logic [NCH-1:0] db_hi, db_lo;

    spwm_deadband #(.DEADTIME(DEADTIME)) u_db [NCH-1:0] (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .raw    (raw),
        .pwm_hi (db_hi),
        .pwm_lo (db_lo)
    );

    assign bus.pwm_out = db_hi;
    assign bus.pwm_n   = db_lo;
`else
    // DEADTIME only shapes the dead-band build.
    if (DEADTIME < 0) begin : g_dt_unused
    end

    assign bus.pwm_out = raw;
    assign bus.pwm_n   = ~raw;
`endif
endmodule

// File: tb/tb_spwm_carrier_pwm.sv
// Scoreboard bench for spwm_carrier_pwm: phase-based reference model, randomized stimulus.
module tb_spwm_carrier_pwm;
    localparam int W   = 15;
    localparam int NCH = 3;
    localparam int DW  = 4;
    localparam int PD  = 15358;

    typedef struct {
        int           carrier;
        bit           dir;
        bit           sync;
        bit           top;
        bit [NCH-1:0] po;
        bit [NCH-1:0] pn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    spwm_carrier_pwm_if #(.WIDTH(W), .NCH(NCH), .DWELL_W(DW)) bus ();

    spwm_carrier_pwm dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   mod_v[NCH];

    // Reference model: position t inside the current period plus the active parameters.
    int m_t, m_pk, m_dw;
    int m_act[NCH], m_sh[NCH];
    bit m_raw[NCH];
    bit m_sync, m_top;

    function automatic int car_of(int t);
        if (t <= m_dw) return 0;
        if (t < m_dw + m_pk) return t - m_dw;
        if (t <= 2 * m_dw + m_pk) return m_pk;
        return 2 * m_dw + 2 * m_pk - t;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input int pk, input int dw, input bit wr);
        if (r) begin
            m_t = 0; m_pk = PD; m_dw = 0; m_sync = 0; m_top = 0;
            for (int i = 0; i < NCH; i++) begin m_act[i] = 0; m_sh[i] = 0; m_raw[i] = 0; end
            return;
        end
        if (e) begin
            for (int i = 0; i < NCH; i++) m_raw[i] = m_act[i] > car_of(m_t);
            m_t++;
            if (m_t == 2 * m_pk + 2 * m_dw) begin
                m_t  = 0;
                m_pk = (pk == 0) ? 1 : pk;
                m_dw = dw;
                for (int i = 0; i < NCH; i++) m_act[i] = m_sh[i];
            end
            m_sync = (m_t == 0);
            m_top  = (m_t == m_dw + m_pk);
        end
        if (wr) for (int i = 0; i < NCH; i++) m_sh[i] = mod_v[i];
    endtask

    task automatic step(input bit r, input bit e, input int pk, input int dw, input bit wr);
        logic [NCH*W-1:0] mv;
        exp_t x;
        @(negedge clk);
        for (int i = 0; i < NCH; i++) mv[i*W +: W] = W'(mod_v[i]);
        rst        = r;
        bus.en     = e;
        bus.peak   = W'(pk);
        bus.dwell  = DW'(dw);
        bus.mod_in = mv;
        bus.mod_wr = wr;
        model_step(r, e, pk, dw, wr);
        x.carrier = car_of(m_t);
        x.dir     = m_t < m_dw + m_pk;
        x.sync    = m_sync;
        x.top     = m_top;
        for (int i = 0; i < NCH; i++) begin
            x.po[i] = m_raw[i];
            x.pn[i] = ~m_raw[i];
        end
        q.push_back(x);
    endtask

    task automatic run(input int n, input int pk, input int dw);
        for (int i = 0; i < n; i++) step(0, 1, pk, dw, 0);
    endtask

    // Monitor: every clock the DUT presents one output vector, matched against the queue head.
    exp_t e_mon;
    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            chk("carrier", int'(bus.carrier), e_mon.carrier);
            chk("dir_up", int'(bus.dir_up), int'(e_mon.dir));
            chk("sync_pulse", int'(bus.sync_pulse), int'(e_mon.sync));
            chk("top_pulse", int'(bus.top_pulse), int'(e_mon.top));
            chk("pwm_out", int'(bus.pwm_out), int'(e_mon.po));
            chk("pwm_n", int'(bus.pwm_n), int'(e_mon.pn));
        end
    end

    initial begin
        bus.en = 0; bus.peak = '0; bus.dwell = '0; bus.mod_in = '0; bus.mod_wr = 0;
        for (int i = 0; i < NCH; i++) mod_v[i] = 0;
        model_step(1, 0, 0, 0, 0);

        // Reset state, then the first (default-peak) period with peak 4 requested
        step(1, 0, 4, 0, 0);
        step(1, 1, 4, 0, 0);
        for (int i = 0; i < 2 * PD + 10; i++) begin
            mod_v[0] = 3; mod_v[1] = 5; mod_v[2] = 0;
            step(0, 1, 4, 0, i == 100);
            if (i > 10 && m_t == 0) break;
        end
        run(20, 4, 0);

        // Dwell at both ends
        run(30, 3, 2);

        // Shadow write mid-RISE, then a write landing on the valley-load edge
        for (int i = 0; i < 40 && !(m_t > m_dw && m_t < m_dw + m_pk); i++) run(1, 4, 0);
        mod_v[0] = 2;
        step(0, 1, 4, 0, 1);
        run(20, 4, 0);
        for (int i = 0; i < 40 && m_t != 2 * m_pk + 2 * m_dw - 1; i++) run(1, 4, 0);
        mod_v[0] = 1;
        step(0, 1, 4, 0, 1);
        run(20, 4, 0);

        // Peak clamp, peak 1, then mod 0 / mod 5 extremes with peak 4
        run(20, 0, 0);
        run(12, 1, 0);
        mod_v[0] = 0; mod_v[1] = 5; mod_v[2] = 4;
        step(0, 1, 4, 0, 1);
        run(30, 4, 0);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            bit wr;
            wr = ($urandom_range(0, 9) == 0);
            if (wr) for (int c = 0; c < NCH; c++) mod_v[c] = $urandom_range(0, 7);
            step(0, $urandom_range(0, 9) != 0, $urandom_range(0, 6), $urandom_range(0, 3), wr);
        end

        // Freeze mid-FALL, then reset pulse
        run(40, 4, 0);
        for (int i = 0; i < 40 && !(m_t > 2 * m_dw + m_pk + 1); i++) run(1, 4, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 4, 0, 0);
        step(1, 1, 4, 0, 0);
        run(8, 4, 0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
